// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: opcodes, control-word layout
// and default geometry.
package control_sequencer_pkg;

    localparam int OPW_DEF   = 4;
    localparam int STEPS_DEF = 5;
    localparam int SW_DEF    = 3;
    localparam int CW_W      = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Bit positions within the control word
    localparam int CW_PC_OE    = 0;
    localparam int CW_PC_INC   = 1;
    localparam int CW_PC_JMP   = 2;
    localparam int CW_MAR_IN   = 3;
    localparam int CW_RAM_OE   = 4;
    localparam int CW_RAM_IN   = 5;
    localparam int CW_IR_IN    = 6;
    localparam int CW_IR_OE    = 7;
    localparam int CW_A_IN     = 8;
    localparam int CW_A_OE     = 9;
    localparam int CW_B_IN     = 10;
    localparam int CW_ALU_OE   = 11;
    localparam int CW_ALU_SUB  = 12;
    localparam int CW_FLAGS_IN = 13;
    localparam int CW_OUT_IN   = 14;
    localparam int CW_HALT     = 15;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath connection: instruction/flag inputs and control strobes.
interface control_sequencer_if
    import control_sequencer_pkg::*;
#(
    parameter int OPW = OPW_DEF,
    parameter int SW  = SW_DEF
);
    logic [OPW-1:0] opcode;
    logic           carry_flag;
    logic           zero_flag;
    logic           pc_oe;
    logic           pc_inc;
    logic           pc_jmp;
    logic           mar_in;
    logic           ram_oe;
    logic           ram_in;
    logic           ir_in;
    logic           ir_oe;
    logic           a_in;
    logic           a_oe;
    logic           b_in;
    logic           alu_oe;
    logic           alu_sub;
    logic           flags_in;
    logic           out_in;
    logic           halt;
    logic [SW-1:0]  step;

    modport seq (
        input  opcode, carry_flag, zero_flag,
        output pc_oe, pc_inc, pc_jmp, mar_in, ram_oe, ram_in, ir_in, ir_oe,
               a_in, a_oe, b_in, alu_oe, alu_sub, flags_in, out_in, halt, step
    );

    modport dp (
        output opcode, carry_flag, zero_flag,
        input  pc_oe, pc_inc, pc_jmp, mar_in, ram_oe, ram_in, ir_in, ir_oe,
               a_in, a_oe, b_in, alu_oe, alu_sub, flags_in, out_in, halt, step
    );
endinterface

// File: rtl/control_sequencer_rom.sv
// Combinational microcode table: (step, opcode, flags) -> control word.
// The halt bit here only marks T2 of HLT; the sequencer turns it into state.
module control_rom
    import control_sequencer_pkg::*;
#(
    parameter int OPW = OPW_DEF,
    parameter int SW  = SW_DEF
) (
    input  logic [SW-1:0]  step,
    input  logic [OPW-1:0] opcode,
    input  logic           carry_flag,
    input  logic           zero_flag,
    output ctrl_word_t     cw
);

    always_comb begin
        cw = '0;
        case (step)
            SW'(0): begin
                cw[CW_PC_OE]  = 1'b1;
                cw[CW_MAR_IN] = 1'b1;
            end
            SW'(1): begin
                cw[CW_RAM_OE] = 1'b1;
                cw[CW_IR_IN]  = 1'b1;
                cw[CW_PC_INC] = 1'b1;
            end
            SW'(2): begin
                case (opcode)
                    OPW'(OP_LDA), OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_STA): begin
                        cw[CW_IR_OE]  = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end
                    OPW'(OP_LDI): begin
                        cw[CW_IR_OE] = 1'b1;
                        cw[CW_A_IN]  = 1'b1;
                    end
                    OPW'(OP_JMP): begin
                        cw[CW_IR_OE]  = 1'b1;
                        cw[CW_PC_JMP] = 1'b1;
                    end
                    // Untaken conditional jumps still spend the full instruction time
                    OPW'(OP_JC): begin
                        cw[CW_IR_OE]  = 1'b1;
                        cw[CW_PC_JMP] = carry_flag;
                    end
                    OPW'(OP_JZ): begin
                        cw[CW_IR_OE]  = 1'b1;
                        cw[CW_PC_JMP] = zero_flag;
                    end
                    OPW'(OP_OUT): begin
                        cw[CW_A_OE]   = 1'b1;
                        cw[CW_OUT_IN] = 1'b1;
                    end
                    OPW'(OP_HLT): begin
                        cw[CW_HALT] = 1'b1;
                    end
                    default: ;
                endcase
            end
            SW'(3): begin
                case (opcode)
                    OPW'(OP_LDA): begin
                        cw[CW_RAM_OE] = 1'b1;
                        cw[CW_A_IN]   = 1'b1;
                    end
                    OPW'(OP_ADD), OPW'(OP_SUB): begin
                        cw[CW_RAM_OE] = 1'b1;
                        cw[CW_B_IN]   = 1'b1;
                    end
                    OPW'(OP_STA): begin
                        cw[CW_A_OE]   = 1'b1;
                        cw[CW_RAM_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            SW'(4): begin
                case (opcode)
                    OPW'(OP_ADD), OPW'(OP_SUB): begin
                        cw[CW_ALU_OE]   = 1'b1;
                        cw[CW_A_IN]     = 1'b1;
                        cw[CW_FLAGS_IN] = 1'b1;
                        cw[CW_ALU_SUB]  = (opcode == OPW'(OP_SUB));
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer: owns step/halted state, gates the microcode word with
// clr and halted, and exposes halt during T2 of HLT as well as afterwards.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OPW   = OPW_DEF,
    parameter int STEPS = STEPS_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic              clk,
    input  logic              clr,
    control_sequencer_if.seq  bus
);

    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    logic [SW-1:0] step_reg, step_next;
    logic          halted_reg, halted_next;
    ctrl_word_t    rom_cw;
    ctrl_word_t    gated_cw;
    logic          run;

    control_rom #(
        .OPW (OPW),
        .SW  (SW)
    ) u_rom (
        .step       (step_reg),
        .opcode     (bus.opcode),
        .carry_flag (bus.carry_flag),
        .zero_flag  (bus.zero_flag),
        .cw         (rom_cw)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            step_reg   <= '0;
            halted_reg <= 1'b0;
        end else begin
            step_reg   <= step_next;
            halted_reg <= halted_next;
        end
    end

    // The halting edge also holds step, so a halted machine sits at T2
    always_comb begin
        step_next   = step_reg;
        halted_next = halted_reg;
        if (!halted_reg) begin
            if (rom_cw[CW_HALT]) begin
                halted_next = 1'b1;
            end else if (step_reg == LAST_STEP) begin
                step_next = '0;
            end else begin
                step_next = step_reg + SW'(1);
            end
        end
    end

    assign run = !clr && !halted_reg;

    for (genvar gi = 0; gi < CW_W; gi++) begin : g_gate
        assign gated_cw[gi] = rom_cw[gi] & run;
    end

    assign bus.pc_oe    = gated_cw[CW_PC_OE];
    assign bus.pc_inc   = gated_cw[CW_PC_INC];
    assign bus.pc_jmp   = gated_cw[CW_PC_JMP];
    assign bus.mar_in   = gated_cw[CW_MAR_IN];
    assign bus.ram_oe   = gated_cw[CW_RAM_OE];
    assign bus.ram_in   = gated_cw[CW_RAM_IN];
    assign bus.ir_in    = gated_cw[CW_IR_IN];
    assign bus.ir_oe    = gated_cw[CW_IR_OE];
    assign bus.a_in     = gated_cw[CW_A_IN];
    assign bus.a_oe     = gated_cw[CW_A_OE];
    assign bus.b_in     = gated_cw[CW_B_IN];
    assign bus.alu_oe   = gated_cw[CW_ALU_OE];
    assign bus.alu_sub  = gated_cw[CW_ALU_SUB];
    assign bus.flags_in = gated_cw[CW_FLAGS_IN];
    assign bus.out_in   = gated_cw[CW_OUT_IN];
    assign bus.halt     = (halted_reg && !clr) || gated_cw[CW_HALT];
    assign bus.step     = step_reg;

endmodule
